uart_cmd_parser: RTL and testbench

- Consumes the byte stream from the UART receiver (rx_data/rx_valid) and decodes fixed 7-byte command frames.
- Executes register writes and reads against an internal parameter register bank, which drives the video pipeline's runtime controls.
- Returns a 5-byte response frame through the UART transmitter's tx_data/tx_valid/tx_req interface.
- Sits directly downstream of the UART receive path and upstream of the UART transmit path.

---
 rtl/uart_cmd_parser.sv | 180 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Decodes 7-byte command frames (55 AA CMD ADDR DH DL CSUM) from the UART
//   receiver. Writes and reads go to an internal bank of 16-bit registers, and
//   every accepted frame gets a 5-byte response (A5 STATUS ADDR D_hi D_lo)
//   through the transmitter handshake.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   tx_data, tx_valid   response byte and its one-cycle load strobe
//   tx_req              transmitter idle / ready for a byte
//   reg_wr_en           one-cycle pulse per successful write
//   reg_addr, reg_wdata address/data of the last write (held)
//   reg_bank            flat register contents, reg N at [16N+15:16N]
//   csum_err_cnt        saturating count of checksum-failed frames
//
// State table
//   HUNT0 | waiting for sync byte 0x55
//   HUNT1 | got 0x55, waiting for 0xAA
//   CMD   | waiting for command byte
//   ADDR  | waiting for address byte
//   DH    | waiting for data high byte
//   DL    | waiting for data low byte
//   CSUM  | waiting for checksum byte
//   EXEC  | one cycle: check frame, do write/read, set status
//   RESP  | sending the 5 response bytes
module uart_cmd_parser #(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_req,
  output logic                     reg_wr_en,
  output logic [7:0]               reg_addr,
  output logic [15:0]              reg_wdata,
  output logic [16*NUM_REGS-1:0]   reg_bank,
  output logic [7:0]               csum_err_cnt
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    NREGS_9B  = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    S_HUNT0, S_HUNT1, S_CMD, S_ADDR, S_DH, S_DL, S_CSUM, S_EXEC, S_RESP
  } state_t;

  state_t        state;
  logic [7:0]    cmd_q, addr_q, dh_q, dl_q, csum_q;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    status_q;
  logic [15:0]   resp_data;
  logic [2:0]    tx_idx;
  logic [1:0]    hold;
  logic [15:0]   regs [NUM_REGS];

  logic [7:0]    sum;
  logic          csum_ok, cmd_ok, addr_ok;
  logic [15:0]   rd_word;
  logic [7:0]    tx_byte;

  always_comb begin
    sum     = cmd_q + addr_q + dh_q + dl_q;
    csum_ok = (sum == csum_q);
    cmd_ok  = (cmd_q == 8'h01) || (cmd_q == 8'h02);
    addr_ok = ({1'b0, addr_q} < NREGS_9B);
    rd_word = addr_ok ? regs[addr_q[AW-1:0]] : 16'h0000;
    case (tx_idx)
      3'd0:    tx_byte = 8'hA5;
      3'd1:    tx_byte = status_q;
      3'd2:    tx_byte = addr_q;
      3'd3:    tx_byte = resp_data[15:8];
      default: tx_byte = resp_data[7:0];
    endcase
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
    assign reg_bank[16*i +: 16] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_HUNT0;
      cmd_q        <= '0;
      addr_q       <= '0;
      dh_q         <= '0;
      dl_q         <= '0;
      csum_q       <= '0;
      tmo_cnt      <= '0;
      status_q     <= '0;
      resp_data    <= '0;
      tx_idx       <= '0;
      hold         <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      reg_wr_en    <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      csum_err_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      tx_valid  <= 1'b0;
      reg_wr_en <= 1'b0;
      case (state)
        S_HUNT0: if (rx_valid && rx_data == 8'h55) state <= S_HUNT1;
        S_HUNT1: begin
          if (rx_valid) begin
            if (rx_data == 8'hAA) begin
              state   <= S_CMD;
              tmo_cnt <= TMO_LOAD;
            end else if (rx_data != 8'h55) begin
              state <= S_HUNT0;
            end
          end
        end
        S_CMD, S_ADDR, S_DH, S_DL, S_CSUM: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (rx_valid) begin
            tmo_cnt <= TMO_LOAD;
            case (state)
              S_CMD:   begin cmd_q  <= rx_data; state <= S_ADDR; end
              S_ADDR:  begin addr_q <= rx_data; state <= S_DH;   end
              S_DH:    begin dh_q   <= rx_data; state <= S_DL;   end
              S_DL:    begin dl_q   <= rx_data; state <= S_CSUM; end
              default: begin csum_q <= rx_data; state <= S_EXEC; end
            endcase
          end else if (tmo_cnt == '0) begin
            state <= S_HUNT0;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_EXEC: begin
          tx_idx <= '0;
          hold   <= '0;
          state  <= S_RESP;
          if (!csum_ok) begin
            status_q  <= 8'h01;
            resp_data <= '0;
            if (csum_err_cnt != 8'hFF) csum_err_cnt <= csum_err_cnt + 1'b1;
          end else if (!cmd_ok || !addr_ok) begin
            status_q  <= 8'h02;
            resp_data <= '0;
          end else begin
            status_q <= 8'h00;
            if (cmd_q == 8'h01) begin
              regs[addr_q[AW-1:0]] <= {dh_q, dl_q};
              reg_wr_en            <= 1'b1;
              reg_addr             <= addr_q;
              reg_wdata            <= {dh_q, dl_q};
              resp_data            <= {dh_q, dl_q};
            end else begin
              resp_data <= rd_word;
            end
          end
        end
        S_RESP: begin
          // hold masks tx_req for two cycles after each pulse.
          if (hold != 2'd0) begin
            hold <= hold - 1'b1;
          end else if (tx_req) begin
            tx_data  <= tx_byte;
            tx_valid <= 1'b1;
            hold     <= 2'd2;
            if (tx_idx == 3'd4) state <= S_HUNT0;
            else                tx_idx <= tx_idx + 1'b1;
          end
        end
        default: state <= S_HUNT0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed frames, a frame-level model of the
// expected responses/writes, and a per-cycle compare process.
module tb_uart_cmd_parser;
  localparam int NUM_REGS = 16;
  localparam int TMO      = 27000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             rx_data = 8'h00;
  logic                   rx_valid = 1'b0;
  logic                   tx_req = 1'b1;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   reg_wr_en;
  logic [7:0]             reg_addr;
  logic [15:0]            reg_wdata;
  logic [16*NUM_REGS-1:0] reg_bank;
  logic [7:0]             csum_err_cnt;

  always #5 clk = ~clk;

  uart_cmd_parser #(.NUM_REGS(NUM_REGS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_req(tx_req),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_bank(reg_bank), .csum_err_cnt(csum_err_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_tx[$];
  logic [23:0] exp_wr[$];
  logic [7:0]  tx_log[$];
  logic [15:0] arch_reg[NUM_REGS];
  logic [15:0] vis_reg[NUM_REGS];
  int          model_cerr = 0;
  bit          in_reset = 1'b1;
  bit          prev_txv = 1'b0;
  int          tx_first_cyc = 0;
  int          tx_total = 0;
  logic [23:0] w_cmp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_bank(input string name);
    logic [16*NUM_REGS-1:0] e;
    for (int i = 0; i < NUM_REGS; i++) e[16*i +: 16] = vis_reg[i];
    n_cmp++;
    if (reg_bank !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, reg_bank, e, cyc);
    end
  endtask

  // Frame-level model: what the response and any write must be.
  task automatic apply_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] h, input logic [7:0] l,
                             input logic [7:0] s);
    logic [7:0]  st;
    logic [15:0] d;
    int          total;
    total = (int'(c) + int'(a) + int'(h) + int'(l)) % 256;
    d = 16'h0000;
    if (total != int'(s)) begin
      st = 8'h01;
      if (model_cerr < 255) model_cerr++;
    end else if ((c != 8'h01 && c != 8'h02) || int'(a) >= NUM_REGS) begin
      st = 8'h02;
    end else begin
      st = 8'h00;
      if (c == 8'h01) begin
        d = {h, l};
        arch_reg[a] = d;
        exp_wr.push_back({a, d});
      end else begin
        d = arch_reg[a];
      end
    end
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(st);
    exp_tx.push_back(a);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      if (tx_valid) begin
        check("tx_back_to_back", {31'b0, prev_txv}, 32'd0);
        if (tx_log.size() == 0) tx_first_cyc = cyc;
        tx_log.push_back(tx_data);
        tx_total++;
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected: got byte %02h, none expected (cycle %0d)", tx_data, cyc);
        end else begin
          check("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
      prev_txv = tx_valid;
      if (reg_wr_en) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_unexpected: got addr %02h data %04h, none expected", reg_addr, reg_wdata);
        end else begin
          w_cmp = exp_wr.pop_front();
          check("wr_addr", reg_addr, w_cmp[23:16]);
          check("wr_data", reg_wdata, w_cmp[15:0]);
          vis_reg[w_cmp[23:16]] = w_cmp[15:0];
        end
      end
      check_bank("reg_bank");
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] s);
    send_byte(8'h55); send_byte(8'hAA);
    send_byte(c); send_byte(a); send_byte(h); send_byte(l); send_byte(s);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && k < 3000) begin
      tick(1); k++;
    end
    tick(4);
    check("resp_drain", exp_tx.size() + exp_wr.size(), 0);
  endtask

  task automatic check_log(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    logic [7:0] e[5];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3; e[4] = b4;
    check({name, "_len"}, tx_log.size(), 5);
    if (tx_log.size() == 5)
      for (int i = 0; i < 5; i++) check(name, tx_log[i], e[i]);
  endtask

  task automatic frame_case(input string name, input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] h, input logic [7:0] l, input logic [7:0] s,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    tx_log.delete();
    apply_frame(c, a, h, l, s);
    send_frame(c, a, h, l, s);
    drain();
    check_log(name, 8'hA5, b1, b2, b3, b4);
  endtask

  task automatic clear_model();
    exp_tx.delete();
    exp_wr.delete();
    for (int i = 0; i < NUM_REGS; i++) begin arch_reg[i] = '0; vis_reg[i] = '0; end
    model_cerr = 0;
  endtask

  initial begin
    int csum_edge;
    int base;
    int k;
    clear_model();
    rst_n = 1'b0;
    tick(3);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_cerr", csum_err_cnt, 0);
    check_bank("rst_bank");
    rst_n = 1'b1;
    tick(1);
    in_reset = 1'b0;

    // write reg3 = 1234, with latency check
    tx_log.delete();
    apply_frame(8'h01, 8'h03, 8'h12, 8'h34, 8'h4A);
    send_frame(8'h01, 8'h03, 8'h12, 8'h34, 8'h4A);
    csum_edge = cyc;
    drain();
    check_log("write_resp", 8'hA5, 8'h00, 8'h03, 8'h12, 8'h34);
    check("first_tx_latency", tx_first_cyc - csum_edge, 2);
    check("reg3_lit", reg_bank[63:48], 16'h1234);
    check("addr_hold", reg_addr, 8'h03);
    check("wdata_hold", reg_wdata, 16'h1234);

    frame_case("read_resp", 8'h02, 8'h03, 8'h00, 8'h00, 8'h05, 8'h00, 8'h03, 8'h12, 8'h34);
    frame_case("badsum_resp", 8'h01, 8'h03, 8'h12, 8'h34, 8'h4B, 8'h01, 8'h03, 8'h00, 8'h00);
    check("cerr_one", csum_err_cnt, 8'd1);
    check("cerr_model", csum_err_cnt, model_cerr);
    frame_case("badaddr_resp", 8'h01, 8'h10, 8'h12, 8'h34, 8'h57, 8'h02, 8'h10, 8'h00, 8'h00);
    frame_case("badcmd_resp", 8'h03, 8'h05, 8'h00, 8'h01, 8'h09, 8'h02, 8'h05, 8'h00, 8'h00);

    // resync on repeated 0x55
    tx_log.delete();
    apply_frame(8'h01, 8'h00, 8'h00, 8'h07, 8'h08);
    send_byte(8'h55);
    send_frame(8'h01, 8'h00, 8'h00, 8'h07, 8'h08);
    drain();
    check_log("resync_resp", 8'hA5, 8'h00, 8'h00, 8'h00, 8'h07);
    check("reg0_lit", reg_bank[15:0], 16'h0007);

    // stale partial frame is discarded after the timeout
    tx_log.delete();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    tick(TMO + 1);
    apply_frame(8'h01, 8'h05, 8'hAB, 8'hCD, 8'h7E);
    send_frame(8'h01, 8'h05, 8'hAB, 8'hCD, 8'h7E);
    drain();
    check_log("timeout_resp", 8'hA5, 8'h00, 8'h05, 8'hAB, 8'hCD);

    // a long gap just under the timeout keeps the frame alive
    tx_log.delete();
    apply_frame(8'h01, 8'h09, 8'h00, 8'h42, 8'h4C);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h09);
    tick(TMO - 10);
    send_byte(8'h00); send_byte(8'h42); send_byte(8'h4C);
    drain();
    check_log("slow_resp", 8'hA5, 8'h00, 8'h09, 8'h00, 8'h42);

    // flow control: nothing leaves while tx_req is low
    tx_log.delete();
    tx_req = 1'b0;
    apply_frame(8'h01, 8'h07, 8'hBE, 8'hEF, 8'hB5);
    send_frame(8'h01, 8'h07, 8'hBE, 8'hEF, 8'hB5);
    base = tx_total;
    tick(1000);
    check("hold_no_tx", tx_total - base, 0);
    tx_req = 1'b1;
    drain();
    check_log("flow_resp", 8'hA5, 8'h00, 8'h07, 8'hBE, 8'hEF);

    // checksum error counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      tx_log.delete();
      apply_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
      send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
      drain();
    end
    check("cerr_sat", csum_err_cnt, 8'd255);
    check("cerr_sat_model", csum_err_cnt, model_cerr);

    // reset in the middle of a response
    tx_log.delete();
    apply_frame(8'h02, 8'h07, 8'h00, 8'h00, 8'h09);
    send_frame(8'h02, 8'h07, 8'h00, 8'h00, 8'h09);
    k = 0;
    while (tx_log.size() < 2 && k < 200) begin tick(1); k++; end
    check("resp_partial", tx_log.size(), 2);
    in_reset = 1'b1;
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_cerr", csum_err_cnt, 0);
    clear_model();
    check_bank("rst_mid_bank");
    tick(2);
    check("rst_mid_tx_valid2", tx_valid, 0);
    rst_n = 1'b1;
    tick(1);
    prev_txv = 1'b0;
    in_reset = 1'b0;
    tick(20);

    frame_case("post_rst_write", 8'h01, 8'h02, 8'h01, 8'h02, 8'h06, 8'h00, 8'h02, 8'h01, 8'h02);
    check("reg2_lit", reg_bank[47:32], 16'h0102);
    frame_case("post_rst_read", 8'h02, 8'h03, 8'h00, 8'h00, 8'h05, 8'h00, 8'h03, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
